// File: rtl/arith_response_checker.sv
// Stimulus sequencer and response checker for a 4-bit arithmetic circuit:
// sweeps all eight {Cin,s1,s0} codes over one latched operand pair and scores F/Cout.
module arith_response_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic [3:0] drv_a,
    output logic [3:0] drv_b,
    output logic       drv_cin,
    output logic       drv_s1,
    output logic       drv_s0,
    input  logic [3:0] dut_f,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    // Expected {Cout,F} of the arithmetic circuit for one operand pair and select code.
    function automatic logic [4:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] code);
        logic [3:0] y;
        case (code[1:0])
            2'b00:   y = 4'b0000;
            2'b01:   y = b;
            2'b10:   y = ~b;
            2'b11:   y = 4'b1111;
            default: y = 4'b0000;
        endcase
        return {1'b0, a} + {1'b0, y} + {4'b0000, code[2]};
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [2:0] code_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] err_r;
    logic       fail_valid_r;
    logic [2:0] first_fail_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [4:0] ref_s;
    logic       mismatch_s;
    logic [3:0] err_next_s;

    // Reference value and mismatch detection for the code currently on the bus.
    always_comb begin
        ref_s      = ref_calc(a_r, b_r, code_r);
        mismatch_s = 1'b0;
        err_next_s = err_r;
        if (state_r == ST_SAMPLE) begin
            mismatch_s = ({dut_cout, dut_f} != ref_s);
        end else begin
            mismatch_s = 1'b0;
        end
        if (mismatch_s && (err_r != 4'd8)) begin
            err_next_s = err_r + 4'd1;
        end else begin
            err_next_s = err_r;
        end
    end

    // Next-state logic; a zero settle time skips DRIVE so each code window is one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (SETTLE_C == 4'd0) ? ST_SAMPLE : ST_DRIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == SETTLE_C - 4'd1) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (code_r == 3'd7) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = (SETTLE_C == 4'd0) ? ST_SAMPLE : ST_DRIVE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, code sequencing, settle counter and result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= 4'd0;
            code_r       <= 3'd0;
            a_r          <= 4'd0;
            b_r          <= 4'd0;
            err_r        <= 4'd0;
            fail_valid_r <= 1'b0;
            first_fail_r <= 3'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r          <= a_in;
                        b_r          <= b_in;
                        code_r       <= 3'd0;
                        cnt_r        <= 4'd0;
                        err_r        <= 4'd0;
                        fail_valid_r <= 1'b0;
                        first_fail_r <= 3'd0;
                        pass_r       <= 1'b0;
                        busy_r       <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    cnt_r <= (state_s == ST_SAMPLE) ? 4'd0 : cnt_r + 4'd1;
                end
                ST_SAMPLE: begin
                    err_r <= err_next_s;
                    if (mismatch_s && !fail_valid_r) begin
                        fail_valid_r <= 1'b1;
                        first_fail_r <= code_r;
                    end
                    // pass is taken from the count that includes this final compare.
                    if (code_r == 3'd7) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (err_next_s == 4'd0);
                    end else begin
                        code_r <= code_r + 3'd1;
                        cnt_r  <= 4'd0;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign drv_a      = a_r;
    assign drv_b      = b_r;
    assign drv_cin    = code_r[2];
    assign drv_s1     = code_r[1];
    assign drv_s0     = code_r[0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign fail_valid = fail_valid_r;
    assign first_fail = first_fail_r;

endmodule

// File: doc/arith_response_checker.md
# arith_response_checker

Self-checking sequencer and response checker for the 4-bit arithmetic circuit (select {Cin, s1, s0}). On a start request it latches one operand pair and drives all eight function codes onto the circuit under test in ascending order. It waits a programmable settle time for each code, then samples F/Cout and compares them against an internally computed reference. It reports the error count, a pass flag and the first failing code. It sits beside the arithmetic circuit as its stimulus/response end in on-chip self-test.

## Interface
- SETTLE, 1, extra cycles each code is held before sampling; legal range 0..15.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only while idle.
- a_in  input  4  operand A, latched on the accepted start.
- b_in  input  4  operand B, latched on the accepted start.
- drv_a  output  4  A driven to the circuit under test (latched a_in).
- drv_b  output  4  B driven to the circuit under test (latched b_in).
- drv_cin  output  1  Cin driven to the circuit under test.
- drv_s1  output  1  s1 driven to the circuit under test.
- drv_s0  output  1  s0 driven to the circuit under test.
- dut_f  input  4  F returned by the circuit under test.
- dut_cout  input  1  Cout returned by the circuit under test.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  1 when err_count==0; valid from done until the next accepted start.
- err_count  output  4  number of mismatching codes, 0..8.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail  output  3  {Cin,s1,s0} of the first mismatch; 0 when fail_valid=0.

## Operation
- Reference model: 5-bit sum {Cout,F} = A + Y + Cin, with Y selected by {s1,s0}:
  - 00: Y = 0000 (transfer/increment).
  - 01: Y = B (add).
  - 10: Y = ~B (subtract with borrow).
  - 11: Y = 1111 (decrement).
- Operations are unsigned 4-bit. Cout is bit 4 of the sum. F wraps modulo 16.
- FSM states:
  - IDLE: start=1 latches a_in/b_in, sets code=0, clears err_count/fail_valid/first_fail/pass, and moves to DRIVE.
  - DRIVE: holds code for SETTLE cycles, then moves to SAMPLE. With SETTLE=0 it goes straight to SAMPLE.
  - SAMPLE: one cycle. Compares {dut_cout,dut_f} with the reference.
    - On mismatch, err_count increments. If this is the first mismatch, first_fail=code and fail_valid=1.
    - If code==7, moves to DONE. Otherwise code increments and the FSM returns to DRIVE.
  - DONE: one cycle. done=1, pass=(err_count==0). Returns to IDLE.
- drv_cin/drv_s1/drv_s0 = code[2]/code[1]/code[0]. They are registered and stable throughout each code window.
- start is ignored while busy. No queuing.
- err_count saturates naturally at 8 (4-bit field, max 8 codes).

## Timing
- Reset values: every output is 0, including drv_*, busy, done, pass, err_count, fail_valid and first_fail. The FSM is in IDLE and code=0.
- Reset mid-sweep aborts on the next edge. No done pulse is produced, results are cleared, and a start in the same cycle as rst is dropped.
- Start accepted at edge E0: busy=1 and code 0 appear on drv_* after E0.
- Code k window: S+1 cycles, where S=SETTLE. Compare at edge E0+(k+1)(S+1), using dut_* values present just before that edge.
- busy falls and done rises after edge E0+8(S+1). done lasts exactly one cycle, then the FSM is back in IDLE.
- Total sweep latency (start edge to done high): 8(S+1) cycles.
- A start asserted during the done cycle is ignored. A start asserted in the first IDLE cycle after done is accepted.
- drv_a/drv_b hold the latched operands after done until the next accepted start.

## Test plan
- Golden DUT model, A=1001, B=1100, SETTLE=1: codes 000..111 must be driven in order, and the bench must verify the stimulus. Expected {Cout,F} per code: 0_1001, 1_0101, 0_1100, 1_1000, 0_1010, 1_0110, 0_1101, 1_1001. Required result: done pulse 16 cycles after the start edge, pass=1, err_count=0, fail_valid=0.
- Faulty DUT with Cout stuck at 0, same operands: err_count=4, first_fail=001, fail_valid=1, pass=0.
- SETTLE=0 with A=1111, B=0000: each code window is 1 cycle and done arrives 8 cycles after start. Code 011 must give F=1110 with Cout=1. Code 100 must give F=0000 with Cout=1 (wrap).
- start pulsed repeatedly while busy, plus a new a_in applied mid-sweep: exactly one done, and drv_a holds the originally latched value.
- rst asserted at code 3 of a failing sweep: all outputs are 0 on the next edge and no done pulse occurs. A subsequent start runs a clean full sweep.
- Back-to-back sweeps: a start in the cycle right after done is accepted, and its results are cleared before the new compares begin.
